// File: rtl/otter_pkg.sv
// Shared types, state encodings and store-lane helpers for the OTTER MEM-stage load/store unit.
package otter_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } mem_type_t;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t LSU_IDLE     = 3'd0;
  localparam lsu_state_t LSU_ISSUE    = 3'd1;
  localparam lsu_state_t LSU_WAIT_RSP = 3'd2;
  localparam lsu_state_t LSU_IO       = 3'd3;
  localparam lsu_state_t LSU_DONE     = 3'd4;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  // Unused funct3 encodings count as misaligned so they are suppressed the same way.
  function automatic logic type_misaligned(input logic [2:0] t, input logic [1:0] off);
    case (t)
      LS_B, LS_BU: return 1'b0;
      LS_H, LS_HU: return off[0];
      LS_W:        return off != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] t, input logic [1:0] off);
    case (t)
      LS_B, LS_BU: return 4'b0001 << off;
      LS_H, LS_HU: return 4'b0011 << {off[1], 1'b0};
      default:     return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] t, input logic [31:0] d);
    case (t)
      LS_B, LS_BU: return {4{d[7:0]}};
      LS_H, LS_HU: return {2{d[15:0]}};
      default:     return d;
    endcase
  endfunction

endpackage

// File: rtl/otter_load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it to 32 bits.
module otter_load_extend
  import otter_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    case (off_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (type_i)
      LS_B:    data_o = {{24{byte_v[7]}}, byte_v};
      LS_BU:   data_o = {24'b0, byte_v};
      LS_H:    data_o = {{16{half_v[15]}}, half_v};
      LS_HU:   data_o = {16'b0, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/otter_mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM requests into req/gnt/rvalid memory or one-cycle IOBUS
// accesses, stalls the pipe while outstanding, and returns extended load data to WB.
module otter_mem_access_unit
  import otter_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_m,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] IOBUS_IN,
  output logic [31:0] IOBUS_OUT,
  output logic [31:0] IOBUS_ADDR,
  output logic        IOBUS_WR
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        type_q, type_d;
  logic              rd_q, rd_d;
  logic              abort_q, abort_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       io_addr_q, io_addr_d;
  logic [31:0]       io_out_q, io_out_d;
  logic              io_wr_q, io_wr_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              bus_err_q, bus_err_d;

  logic              access;
  logic              misaligned;
  logic [31:0]       rd_src;
  logic [31:0]       rd_ext;

  assign access     = req_valid & (req_read | req_write);
  assign misaligned = type_misaligned(req_type, req_addr[1:0]);

  // Reset gates the combinational outputs so a mid-transaction reset releases the pipe at once.
  assign stall_m      = ~RESET & access & (state_q != LSU_DONE) & ~misaligned;
  assign misalign_err = ~RESET & access & misaligned & (state_q == LSU_IDLE);

  assign rd_src = (state_q == LSU_IO) ? IOBUS_IN : mem_rdata;

  otter_load_extend u_extend (
    .word_i (rd_src),
    .off_i  (off_q),
    .type_i (type_q),
    .data_o (rd_ext)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    type_d       = type_q;
    rd_d         = rd_q;
    abort_d      = abort_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    io_addr_d    = io_addr_q;
    io_out_d     = io_out_q;
    io_wr_d      = 1'b0;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (access && !misaligned) begin
          off_d   = req_addr[1:0];
          type_d  = req_type;
          rd_d    = ~req_write;
          abort_d = 1'b0;
          if (req_addr >= IO_BASE) begin
            state_d   = LSU_IO;
            io_addr_d = req_addr;
            io_out_d  = req_wdata;
            io_wr_d   = req_write;
          end else begin
            state_d     = LSU_ISSUE;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_be_d    = lane_be(req_type, req_addr[1:0]);
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = lane_wdata(req_type, req_wdata);
          end
        end
      end

      LSU_ISSUE: begin
        abort_d = abort_q | ~req_valid;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (rd_q) begin
            state_d = LSU_WAIT_RSP;
            cnt_d   = '0;
          end else begin
            state_d = LSU_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          bus_err_d    = 1'b1;
          load_data_d  = '0;
          load_valid_d = rd_q & ~abort_d;
          state_d      = LSU_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LSU_WAIT_RSP: begin
        abort_d = abort_q | ~req_valid;
        if (mem_rvalid) begin
          load_data_d  = rd_ext;
          load_valid_d = ~abort_d;
          state_d      = LSU_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d    = 1'b1;
          load_data_d  = '0;
          load_valid_d = ~abort_d;
          state_d      = LSU_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LSU_IO: begin
        abort_d = abort_q | ~req_valid;
        if (rd_q) begin
          load_data_d  = rd_ext;
          load_valid_d = ~abort_d;
        end
        state_d = LSU_DONE;
      end

      LSU_DONE: state_d = LSU_IDLE;

      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      type_q       <= '0;
      rd_q         <= 1'b0;
      abort_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      io_addr_q    <= '0;
      io_out_q     <= '0;
      io_wr_q      <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      type_q       <= type_d;
      rd_q         <= rd_d;
      abort_q      <= abort_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      io_addr_q    <= io_addr_d;
      io_out_q     <= io_out_d;
      io_wr_q      <= io_wr_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign IOBUS_ADDR = io_addr_q;
  assign IOBUS_OUT  = io_out_q;
  assign IOBUS_WR   = io_wr_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_otter_mem_access_unit.sv
// Directed and randomized checks of otter_mem_access_unit against a behavioural load/store model.
module tb_otter_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_read, req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        stall_m;
  logic [31:0] load_data;
  logic        load_valid, misalign_err, bus_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata, IOBUS_IN, IOBUS_OUT, IOBUS_ADDR;
  logic        IOBUS_WR;

  otter_mem_access_unit dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_m(stall_m), .load_data(load_data), .load_valid(load_valid),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .IOBUS_IN(IOBUS_IN), .IOBUS_OUT(IOBUS_OUT), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_WR(IOBUS_WR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Observations gathered over one transaction.
  int          o_stall, o_req, o_lv, o_iowr, o_berr;
  logic        o_we, o_mis, o_done;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_ld, o_bld, o_ioaddr, o_ioout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: size from funct3[1:0], signedness from funct3[2].
  function automatic int nbytes(input logic [2:0] t);
    return 1 << t[1:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] t, input logic [1:0] off);
    int n = nbytes(t);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] t, input logic [31:0] d);
    case (nbytes(t))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] word);
    int n = nbytes(t);
    logic [31:0] v;
    if (n == 4) return word;
    v = (word >> (8 * off)) & ((32'd1 << (8 * n)) - 32'd1);
    if (!t[2] && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // Drives one request and acts as the memory slave; gdly = cycles of mem_req before gnt,
  // rdly = cycles from gnt to rvalid, drop_c >= 0 removes req_valid from that cycle on.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input logic [31:0] iodat,
                         input int gdly, input int rdly, input int drop_c);
    int reqn = 0;
    int rv_at = -1;
    o_stall = 0; o_req = 0; o_lv = 0; o_iowr = 0; o_berr = 0;
    o_we = 1'b0; o_mis = 1'b0; o_done = 1'b0;
    o_be = 'x; o_addr = 'x; o_wdata = 'x; o_ld = 'x; o_bld = 'x; o_ioaddr = 'x; o_ioout = 'x;
    mem_rdata = rdat;
    IOBUS_IN  = iodat;
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      mem_rvalid = (c == rv_at);
      mem_gnt    = 1'b0;
      if (mem_req) begin
        if (reqn >= gdly) begin
          mem_gnt = 1'b1;
          if (rd && !wr) rv_at = c + rdly;
        end
        reqn++;
      end
      req_valid = (drop_c < 0) || (c < drop_c);
      req_read  = rd;
      req_write = wr;
      req_type  = t;
      req_addr  = a;
      req_wdata = wd;
      #1;
      if (stall_m) o_stall++;
      if (misalign_err) o_mis = 1'b1;
      if (mem_req) begin
        o_req++; o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
      end
      if (IOBUS_WR) begin
        o_iowr++; o_ioout = IOBUS_OUT;
      end
      o_ioaddr = IOBUS_ADDR;
      if (load_valid) begin
        o_lv++; o_ld = load_data;
      end
      if (bus_err) begin
        o_berr++; o_bld = load_data;
      end
      if ((drop_c < 0 && !stall_m) || (drop_c >= 0 && c >= drop_c + 20)) begin
        o_done = 1'b1;
        break;
      end
    end
    req_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    chk("txn_completed", 32'(o_done), 32'd1);
    @(negedge CLK);
  endtask

  logic [2:0] legal_t [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    RESET = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_type = 3'b000;
    req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; IOBUS_IN = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_io_addr", IOBUS_ADDR, 32'd0);
    chk("rst_io_out", IOBUS_OUT, 32'd0);
    chk("rst_io_wr", 32'(IOBUS_WR), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // SW to memory, same-cycle grant.
    run_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, '0, '0, 0, 1, -1);
    chk("sw_be", 32'(o_be), 32'hF);
    chk("sw_addr", o_addr, 32'h100);
    chk("sw_wdata", o_wdata, 32'hDEAD_BEEF);
    chk("sw_we", 32'(o_we), 32'd1);
    chk("sw_stall", 32'(o_stall), 32'd2);

    // LB / LBU from the top byte lane.
    run_txn(1'b1, 1'b0, 3'b000, 32'h103, '0, 32'h80FF_FF7F, '0, 0, 1, -1);
    chk("lb_data", o_ld, 32'hFFFF_FF80);
    chk("lb_lv", 32'(o_lv), 32'd1);
    chk("lb_stall", 32'(o_stall), 32'd3);
    chk("lb_addr", o_addr, 32'h100);
    run_txn(1'b1, 1'b0, 3'b100, 32'h103, '0, 32'h80FF_FF7F, '0, 0, 1, -1);
    chk("lbu_data", o_ld, 32'h0000_0080);
    chk("lbu_stall", 32'(o_stall), 32'd3);

    // SH to IO space.
    run_txn(1'b0, 1'b1, 3'b001, 32'h1100_0002, 32'h0000_1234, '0, '0, 0, 1, -1);
    chk("io_sh_wr", 32'(o_iowr), 32'd1);
    chk("io_sh_addr", o_ioaddr, 32'h1100_0002);
    chk("io_sh_out", {16'd0, o_ioout[15:0]}, 32'h0000_1234);
    chk("io_sh_noreq", 32'(o_req), 32'd0);
    chk("io_sh_stall", 32'(o_stall), 32'd2);

    // Misaligned LW.
    run_txn(1'b1, 1'b0, 3'b010, 32'h102, '0, '0, '0, 0, 1, -1);
    chk("mis_err", 32'(o_mis), 32'd1);
    chk("mis_stall", 32'(o_stall), 32'd0);
    chk("mis_noreq", 32'(o_req), 32'd0);
    #1;
    chk("mis_noreq_after", 32'(mem_req), 32'd0);

    // LW with no grant: bus error after MAX_WAIT cycles in ISSUE.
    run_txn(1'b1, 1'b0, 3'b010, 32'h300, '0, 32'h1111_1111, '0, 1000, 1, -1);
    chk("to_berr", 32'(o_berr), 32'd1);
    chk("to_ldata", o_bld, 32'd0);
    chk("to_stall", 32'(o_stall), 32'd17);
    run_txn(1'b1, 1'b0, 3'b010, 32'h304, '0, 32'h2468_ACE0, '0, 1, 1, -1);
    chk("after_to_ld", o_ld, 32'h2468_ACE0);

    // Reset while the request is outstanding in ISSUE.
    @(negedge CLK);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_type = 3'b010; req_addr = 32'h200;
    @(negedge CLK);
    #1;
    chk("rst_issue_req_pre", 32'(mem_req), 32'd1);
    RESET = 1'b1;
    #1;
    chk("rst_issue_req", 32'(mem_req), 32'd0);
    chk("rst_issue_stall", 32'(stall_m), 32'd0);
    @(negedge CLK);
    req_valid = 1'b0; RESET = 1'b0;

    // Reset while waiting for the read response.
    @(negedge CLK);
    req_valid = 1'b1;
    @(negedge CLK);
    mem_gnt = mem_req;
    @(negedge CLK);
    mem_gnt = 1'b0;
    #1;
    chk("rst_wait_stall_pre", 32'(stall_m), 32'd1);
    RESET = 1'b1;
    #1;
    chk("rst_wait_stall", 32'(stall_m), 32'd0);
    chk("rst_wait_req", 32'(mem_req), 32'd0);
    chk("rst_wait_lv", 32'(load_valid), 32'd0);
    @(negedge CLK);
    req_valid = 1'b0; RESET = 1'b0;
    @(negedge CLK);
    run_txn(1'b1, 1'b0, 3'b010, 32'h204, '0, 32'hCAFE_F00D, '0, 1, 2, -1);
    chk("post_rst_ld", o_ld, 32'hCAFE_F00D);
    chk("post_rst_stall", 32'(o_stall), 32'd5);

    // req_valid removed mid-transaction: completes silently.
    run_txn(1'b1, 1'b0, 3'b010, 32'h208, '0, 32'h5555_AAAA, '0, 0, 3, 2);
    chk("drop_lv", 32'(o_lv), 32'd0);
    chk("drop_gnt_seen", 32'(o_req), 32'd1);

    // Randomized legal transactions against the model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  t;
      logic [1:0]  off;
      logic        wr, rd, io;
      logic [31:0] a, wd, rw;
      int          gd, rdl, es;
      t   = legal_t[$urandom_range(0, 4)];
      wr  = $urandom_range(0, 1) == 1;
      rd  = !wr || ($urandom_range(0, 7) == 0);
      io  = $urandom_range(0, 4) == 0;
      off = (nbytes(t) == 4) ? 2'd0 :
            (nbytes(t) == 2) ? 2'($urandom_range(0, 1) * 2) : 2'($urandom_range(0, 3));
      a   = io ? (32'h1100_0000 + ($urandom & 32'h0000_FFF0)) : ($urandom & 32'h00FF_FFF0);
      a   = a | 32'(off);
      wd  = $urandom;
      rw  = $urandom;
      gd  = $urandom_range(0, 4);
      rdl = $urandom_range(1, 3);
      run_txn(rd, wr, t, a, wd, rw, rw, gd, rdl, -1);
      es = io ? 2 : (wr ? gd + 2 : gd + rdl + 2);
      chk("rnd_stall", 32'(o_stall), 32'(es));
      chk("rnd_mis", 32'(o_mis), 32'd0);
      if (io) begin
        chk("rnd_io_noreq", 32'(o_req), 32'd0);
        chk("rnd_io_wr", 32'(o_iowr), wr ? 32'd1 : 32'd0);
        chk("rnd_io_addr", o_ioaddr, a);
      end else begin
        chk("rnd_req_cycles", 32'(o_req), 32'(gd + 1));
        chk("rnd_addr", o_addr, {a[31:2], 2'b00});
        chk("rnd_we", 32'(o_we), 32'(wr));
        if (wr) begin
          chk("rnd_be", 32'(o_be), 32'(exp_be(t, off)));
          chk("rnd_wdata", o_wdata, exp_wdata(t, wd));
        end
      end
      if (!wr) begin
        chk("rnd_lv", 32'(o_lv), 32'd1);
        chk("rnd_ld", o_ld, exp_load(t, off, rw));
      end else begin
        chk("rnd_store_nolv", 32'(o_lv), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
